// File: rtl/gpr_mp_if.sv
// Register-file bus: read ports, write/retire ports and the issue-stage scoreboard hooks.
// The issue stage drives the master side; the register file is the slave.
interface gpr_mp_if #(
   parameter int DATA_WIDTH = 64,
   parameter int RF_SIZE    = 5,
   parameter int NR         = 2,
   parameter int NW         = 1
);
   logic [NR*RF_SIZE-1:0]    rs_i;
   logic [NR*DATA_WIDTH-1:0] rs_data_o;
   logic [NR-1:0]            rs_busy_o;
   logic [NW-1:0]            we_i;
   logic [NW*RF_SIZE-1:0]    rd_i;
   logic [NW*DATA_WIDTH-1:0] data_i;
   // issue_valid_i has no ready: an issue is accepted in every cycle it is high.
   logic                     issue_valid_i;
   logic [RF_SIZE-1:0]       issue_rd_i;
   logic [NW-1:0]            wb_clear_i;
   logic                     any_pending_o;

   modport master (
      output rs_i, we_i, rd_i, data_i, issue_valid_i, issue_rd_i, wb_clear_i,
      input  rs_data_o, rs_busy_o, any_pending_o
   );

   modport slave (
      input  rs_i, we_i, rd_i, data_i, issue_valid_i, issue_rd_i, wb_clear_i,
      output rs_data_o, rs_busy_o, any_pending_o
   );
endinterface

// File: rtl/gpr_mp.sv
// Multi-port integer register file with write-first bypass, hardwired x0 and a
// per-register pending scoreboard for RAW hazard detection in the issue stage.
module gpr_mp #(
   parameter int DATA_WIDTH = 64,
   parameter int RF_SIZE    = 5,
   parameter int NR         = 2,
   parameter int NW         = 1
) (
   input  logic     clk,
   input  logic     rst,
   gpr_mp_if.slave  bus
);
   localparam int NREG = 2**RF_SIZE;

   logic [DATA_WIDTH-1:0] r_regs [NREG];
   logic [NREG-1:0]       r_pending;

   logic [RF_SIZE-1:0]    w_rd    [NW];
   logic [DATA_WIDTH-1:0] w_wdata [NW];

   for (genvar j = 0; j < NW; j++) begin : g_wr
      assign w_rd[j]    = bus.rd_i[j*RF_SIZE +: RF_SIZE];
      assign w_wdata[j] = bus.data_i[j*DATA_WIDTH +: DATA_WIDTH];
   end

   // Ascending port order makes the highest-indexed writer win on a shared rd.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      end else begin
         for (int j = 0; j < NW; j++) begin
            if (bus.we_i[j] && (w_rd[j] != '0)) r_regs[w_rd[j]] <= w_wdata[j];
         end
      end
   end

   // Set is applied after clears so a new producer outlives a same-cycle retire.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pending <= '0;
      end else begin
         for (int j = 0; j < NW; j++) begin
            if (bus.wb_clear_i[j] && (w_rd[j] != '0)) r_pending[w_rd[j]] <= 1'b0;
         end
         if (bus.issue_valid_i && (bus.issue_rd_i != '0)) r_pending[bus.issue_rd_i] <= 1'b1;
      end
   end

   for (genvar k = 0; k < NR; k++) begin : g_rd
      logic [RF_SIZE-1:0]    w_rs;
      logic [DATA_WIDTH-1:0] w_data;
      logic                  w_busy;

      assign w_rs = bus.rs_i[k*RF_SIZE +: RF_SIZE];

      // A same-cycle retiring write forwards its data, so the reader is no longer blocked.
      always_comb begin
         w_data = r_regs[w_rs];
         w_busy = r_pending[w_rs];
         for (int j = 0; j < NW; j++) begin
            if (bus.we_i[j] && (w_rd[j] == w_rs)) begin
               w_data = w_wdata[j];
               if (bus.wb_clear_i[j]) w_busy = 1'b0;
            end
         end
         if (rst || (w_rs == '0)) begin
            w_data = '0;
            w_busy = 1'b0;
         end
      end

      assign bus.rs_data_o[k*DATA_WIDTH +: DATA_WIDTH] = w_data;
      assign bus.rs_busy_o[k]                          = w_busy;
   end

   assign bus.any_pending_o = |r_pending;
endmodule

// File: tb/tb_gpr_mp.sv
// Directed and random checks of gpr_mp (NR=2, NW=2): reset, x0, bypass, port priority, scoreboard.
module tb_gpr_mp;
  localparam int DW  = 64;
  localparam int RFS = 5;
  localparam int NR  = 2;
  localparam int NW  = 2;

  logic clk;
  logic rst;
  int   vectors_applied;
  int   miscompares;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model [32];

  gpr_mp_if #(.DATA_WIDTH(DW), .RF_SIZE(RFS), .NR(NR), .NW(NW)) bus ();

  gpr_mp #(.DATA_WIDTH(DW), .RF_SIZE(RFS), .NR(NR), .NW(NW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic idle();
    bus.rs_i          = '0;
    bus.we_i          = '0;
    bus.rd_i          = '0;
    bus.data_i        = '0;
    bus.issue_valid_i = 1'b0;
    bus.issue_rd_i    = '0;
    bus.wb_clear_i    = '0;
  endtask

  task automatic set_rs(input int k, input logic [RFS-1:0] a);
    bus.rs_i[k*RFS +: RFS] = a;
  endtask

  task automatic set_wr(input int j, input logic we, input logic clr,
                        input logic [RFS-1:0] rd, input logic [DW-1:0] d);
    bus.we_i[j]             = we;
    bus.wb_clear_i[j]       = clr;
    bus.rd_i[j*RFS +: RFS]  = rd;
    bus.data_i[j*DW +: DW]  = d;
  endtask

  task automatic issue(input logic [RFS-1:0] rd);
    bus.issue_valid_i = 1'b1;
    bus.issue_rd_i    = rd;
  endtask

  task automatic step();
    @(negedge clk);
    idle();
  endtask

  // scoreboard
  task automatic expect_v(input logic [DW-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs);
    logic [DW-1:0] e;
    vectors_applied++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s scoreboard empty, observed=%h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  function automatic logic [DW-1:0] rd_data(input int k);
    return bus.rs_data_o[k*DW +: DW];
  endfunction

  initial begin
    vectors_applied = 0;
    miscompares     = 0;
    idle();
    rst = 1'b1;
    #1;
    expect_v(0); chk("reset_rs0", rd_data(0));
    expect_v(0); chk("reset_busy", DW'(bus.rs_busy_o));
    expect_v(0); chk("reset_anyp", DW'(bus.any_pending_o));
    step();
    rst = 1'b0;

    // Test 1: async reset wipes x5 and pending state mid-cycle
    step();
    set_wr(0, 1, 0, 5'd5, 64'hDEAD); issue(5'd6); set_rs(0, 5'd5);
    expect_v(64'hDEAD);
    #1 chk("t1_bypass_x5", rd_data(0));
    step();
    set_rs(0, 5'd5); set_rs(1, 5'd6);
    expect_v(64'hDEAD); expect_v(1); expect_v(1);
    #1 chk("t1_array_x5", rd_data(0));
    chk("t1_busy_x6", DW'(bus.rs_busy_o[1]));
    chk("t1_anyp_set", DW'(bus.any_pending_o));
    #2 rst = 1'b1;
    set_wr(1, 1, 0, 5'd5, 64'h1111);
    expect_v(0); expect_v(0); expect_v(0);
    #1 chk("t1_rst_x5", rd_data(0));
    chk("t1_rst_busy", DW'(bus.rs_busy_o[1]));
    chk("t1_rst_anyp", DW'(bus.any_pending_o));
    step();
    rst = 1'b0;
    set_rs(0, 5'd5);
    expect_v(0); expect_v(0);
    #1 chk("t1_post_x5", rd_data(0));
    chk("t1_post_anyp", DW'(bus.any_pending_o));

    // Test 2: write-first bypass then array read
    step();
    set_wr(0, 1, 0, 5'd7, 64'h1234); set_rs(1, 5'd7);
    expect_v(64'h1234);
    #1 chk("t2_bypass", rd_data(1));
    step();
    set_rs(1, 5'd7);
    expect_v(64'h1234);
    #1 chk("t2_array", rd_data(1));

    // Test 3: both ports write x3, port 1 wins
    step();
    set_wr(0, 1, 0, 5'd3, 64'hAA); set_wr(1, 1, 0, 5'd3, 64'hBB);
    set_rs(0, 5'd3); set_rs(1, 5'd3);
    expect_v(64'hBB); expect_v(64'hBB);
    #1 chk("t3_bypass_p0", rd_data(0));
    chk("t3_bypass_p1", rd_data(1));
    step();
    set_rs(0, 5'd3);
    expect_v(64'hBB);
    #1 chk("t3_array", rd_data(0));

    // Test 4: x0 write and issue are ignored
    step();
    set_wr(0, 1, 0, 5'd0, 64'hFFFF); issue(5'd0); set_rs(0, 5'd0);
    expect_v(0); expect_v(0);
    #1 chk("t4_x0_bypass", rd_data(0));
    chk("t4_x0_busy", DW'(bus.rs_busy_o[0]));
    step();
    set_rs(0, 5'd0);
    expect_v(0); expect_v(0); expect_v(0);
    #1 chk("t4_x0_array", rd_data(0));
    chk("t4_x0_busy2", DW'(bus.rs_busy_o[0]));
    chk("t4_anyp", DW'(bus.any_pending_o));

    // Test 5: issue x9 then retire with writeback three cycles later
    step();
    issue(5'd9); set_rs(0, 5'd9);
    expect_v(0);
    #1 chk("t5_busy_t0", DW'(bus.rs_busy_o[0]));
    step();
    set_rs(0, 5'd9);
    expect_v(1); expect_v(1);
    #1 chk("t5_busy_t1", DW'(bus.rs_busy_o[0]));
    chk("t5_anyp_t1", DW'(bus.any_pending_o));
    step();
    set_rs(0, 5'd9);
    expect_v(1);
    #1 chk("t5_busy_t2", DW'(bus.rs_busy_o[0]));
    step();
    set_wr(0, 1, 1, 5'd9, 64'h55); set_rs(0, 5'd9);
    expect_v(0); expect_v(64'h55); expect_v(1);
    #1 chk("t5_busy_t3", DW'(bus.rs_busy_o[0]));
    chk("t5_data_t3", rd_data(0));
    chk("t5_anyp_t3", DW'(bus.any_pending_o));
    step();
    set_rs(0, 5'd9);
    expect_v(0); expect_v(64'h55); expect_v(0);
    #1 chk("t5_busy_t4", DW'(bus.rs_busy_o[0]));
    chk("t5_data_t4", rd_data(0));
    chk("t5_anyp_t4", DW'(bus.any_pending_o));

    // wb_clear without we: busy stays up this cycle, pending clears next
    step();
    issue(5'd10);
    step();
    set_wr(1, 0, 1, 5'd10, 64'h0); set_rs(1, 5'd10);
    expect_v(1);
    #1 chk("kill_busy_same", DW'(bus.rs_busy_o[1]));
    step();
    set_rs(1, 5'd10);
    expect_v(0); expect_v(0);
    #1 chk("kill_busy_next", DW'(bus.rs_busy_o[1]));
    chk("kill_anyp", DW'(bus.any_pending_o));

    // Test 6: same-cycle set and clear of x4, set wins
    step();
    issue(5'd4); set_wr(0, 1, 1, 5'd4, 64'h44); set_rs(0, 5'd4);
    expect_v(0);
    #1 chk("t6_busy_same", DW'(bus.rs_busy_o[0]));
    step();
    set_rs(0, 5'd4);
    expect_v(1); expect_v(1); expect_v(64'h44);
    #1 chk("t6_busy_next", DW'(bus.rs_busy_o[0]));
    chk("t6_anyp", DW'(bus.any_pending_o));
    chk("t6_data", rd_data(0));

    // random writes/reads against a reference model after a clean reset
    step();
    rst = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = '0;
    step();
    rst = 1'b0;
    for (int n = 0; n < 40; n++) begin
      logic [RFS-1:0] rd_v [NW];
      logic [DW-1:0]  d_v  [NW];
      logic           we_v [NW];
      logic [RFS-1:0] rs_v [NR];
      logic [DW-1:0]  e;
      step();
      for (int j = 0; j < NW; j++) begin
        we_v[j] = 1'($urandom_range(0, 1));
        rd_v[j] = RFS'($urandom_range(0, 7));
        d_v[j]  = {32'($urandom), 32'($urandom)};
        set_wr(j, we_v[j], 0, rd_v[j], d_v[j]);
      end
      for (int k = 0; k < NR; k++) begin
        rs_v[k] = RFS'($urandom_range(0, 7));
        set_rs(k, rs_v[k]);
        e = model[rs_v[k]];
        for (int j = 0; j < NW; j++) if (we_v[j] && rd_v[j] == rs_v[k]) e = d_v[j];
        if (rs_v[k] == 0) e = '0;
        expect_v(e);
      end
      #1 chk("rnd_p0", rd_data(0));
      chk("rnd_p1", rd_data(1));
      for (int j = 0; j < NW; j++) if (we_v[j] && rd_v[j] != 0) model[rd_v[j]] = d_v[j];
    end

    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end
endmodule

// File: doc/gpr_mp.md
Name: gpr_mp

Overview:
Parametrised multi-port integer register file. It replaces the single-issue 2R1W GPR in the riscv64i core for the dual-issue/pipelined datapath. It provides NR combinational read ports and NW write ports with write-first bypass, and hardwires x0 to zero. It adds an async-cleared register array and a per-register pending scoreboard that the issue stage uses for RAW hazard detection.

Parameters:
DATA_WIDTH, 64, width of each register.
RF_SIZE, 5, address width; register count is 2**RF_SIZE.
NR, 2, number of read ports.
NW, 1, number of write ports.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
rs_i  input  NR*RF_SIZE  read addresses; port k occupies bits [k*RF_SIZE +: RF_SIZE].
rs_data_o  output  NR*DATA_WIDTH  read data, port k at [k*DATA_WIDTH +: DATA_WIDTH].
rs_busy_o  output  NR  port k's register has an outstanding producer.
we_i  input  NW  write enable per write port.
rd_i  input  NW*RF_SIZE  write addresses, packed as rs_i.
data_i  input  NW*DATA_WIDTH  write data, packed as rs_data_o.
issue_valid_i  input  1  an instruction with destination issue_rd_i is issued this cycle.
issue_rd_i  input  RF_SIZE  destination of the issuing instruction.
wb_clear_i  input  NW  write port j retires its producer; clears pending[rd_j].
any_pending_o  output  1  OR of all pending bits (drain/fence indicator).

Behaviour:
- Reset (async, rst=1): all 2**RF_SIZE registers <= 0 and all pending bits <= 0, immediately, regardless of clk.
  - While rst=1: rs_data_o=0 for every port, rs_busy_o=0, any_pending_o=0. Writes and issues are ignored.
  - Reset mid-operation discards all in-flight pending state.
- x0:
  - Writes to address 0 are dropped.
  - Reads of address 0 return 0 and busy=0.
  - Issue to rd 0 never sets pending[0].
- Write (posedge clk, rst=0): for each j with we_i[j]=1 and rd_j!=0, reg[rd_j] <= data_j.
  - If several ports target the same rd in one cycle, the highest-indexed port wins.
- Read: combinational, zero latency.
  - rs_data_o[k] = data of the highest-indexed j with we_i[j] && rd_j==rs_k && rs_k!=0 (write-first bypass).
  - Otherwise reg[rs_k]; 0 when rs_k==0.
  - Every read port is independent; all ports may read the same address.
- Scoreboard (pending[2**RF_SIZE], registered, posedge clk):
  - Clear: for each j with wb_clear_i[j]=1 and rd_j!=0, pending[rd_j] <= 0. wb_clear_i is only meaningful with we_i asserted; it is still honoured alone (squash/kill path).
  - Set: issue_valid_i && issue_rd_i!=0 gives pending[issue_rd_i] <= 1.
  - Same register set and cleared in one cycle: set wins; the new producer remains outstanding.
  - Re-issue to an already-pending register leaves it at 1 (no counting; the issue stage guarantees in-order WAW).
- Busy: rs_busy_o[k] = pending[rs_k] && !(any j: wb_clear_i[j] && we_i[j] && rd_j==rs_k) && rs_k!=0.
  - A same-cycle writeback makes data available via bypass, so busy drops in that cycle.
  - An issue in cycle t affects rs_busy_o from cycle t+1 only.
- any_pending_o = |pending, registered-state based (no same-cycle bypass).
- Debug $strobe is restricted to simulation builds and must not alter behaviour.

Test Plan:
1. Assert rst asynchronously mid-cycle after writing x5=0xDEAD → rs_data_o for x5 reads 0 immediately; after release, x5 reads 0 and any_pending_o=0.
2. Write port 0 x7=0x1234 with rs_i port1=7 in the same cycle → port1 returns 0x1234 combinationally; next cycle it returns 0x1234 from the array.
3. NW=2: both ports write x3 (port0=0xAA, port1=0xBB) → same-cycle bypass and subsequent read both give 0xBB.
4. Write x0=0xFFFF plus issue rd=0 → x0 reads 0, rs_busy=0, any_pending_o stays 0.
5. Issue rd=9 at t → rs_busy for x9 is 0 at t and 1 at t+1. At t+3, we+wb_clear on x9=0x55 → busy=0 and data=0x55 in t+3; pending clear from t+4.
6. Issue rd=4 and wb_clear x4 in the same cycle → pending[4] stays 1 and any_pending_o=1 next cycle.
